pwm_multichan: RTL and testbench

//  Parametrised multi-channel PWM generator; successor to the single 3-bit-switch PWM.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_timebase.sv | 96 +++++++++
 rtl/pwm_multichan.sv | 79 +++++++
 tb/tb_pwm_multichan.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
//   pwm_mode_e : edge- or centre-aligned counting
//   pwm_dir_e  : counter direction in centre-aligned mode
//   ch_width() : channel-index width, never below one bit
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/centre counter, period boundary strobes.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                run enable; low holds prescaler/counter at 0
//   center_mode       requested alignment, taken at a boundary
//   presc             prescaler divide-minus-one, used live
//   period            requested period value, taken at a boundary
//   counter           current counter value
//   load              combinational: this clock edge is a period boundary
//   run               combinational: enabled and past the forced first boundary
//   period_tick       registered one-cycle pulse following each boundary
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               center_mode,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   period,
    output logic [WIDTH-1:0]   counter,
    output logic               load,
    output logic               run,
    output logic               period_tick
);

    logic [PRESC_W-1:0] psc;
    logic [WIDTH-1:0]   p_act;
    logic [WIDTH-1:0]   cnt_nxt;
    pwm_mode_e          mode_act;
    pwm_dir_e           dir;
    pwm_dir_e           dir_nxt;
    logic               en_q;
    logic               tick;

    always_comb begin
        // ">=" so that lowering presc below the running count ticks at once
        tick    = (psc >= presc);
        cnt_nxt = counter;
        dir_nxt = dir;
        if (mode_act == PWM_EDGE) begin
            cnt_nxt = (counter >= p_act) ? '0 : counter + 1'b1;
        end else if (dir == DIR_UP) begin
            if (counter >= p_act) begin
                // Turn at the top; P_act=0 stays at 0 so every tick is a boundary
                cnt_nxt = (counter == '0) ? '0 : counter - 1'b1;
                dir_nxt = DIR_DOWN;
            end else begin
                cnt_nxt = counter + 1'b1;
            end
        end else begin
            cnt_nxt = counter - 1'b1;
        end
        run  = en && en_q;
        // The first enabled cycle is a forced boundary
        load = en && (!en_q || (tick && (cnt_nxt == '0)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc         <= '0;
            counter     <= '0;
            dir         <= DIR_UP;
            p_act       <= '0;
            mode_act    <= PWM_EDGE;
            en_q        <= 1'b0;
            period_tick <= 1'b0;
        end else if (!en) begin
            psc         <= '0;
            counter     <= '0;
            dir         <= DIR_UP;
            en_q        <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            en_q        <= 1'b1;
            period_tick <= load;
            if (load) begin
                psc      <= '0;
                counter  <= '0;
                dir      <= DIR_UP;
                p_act    <= period;
                mode_act <= pwm_mode_e'(center_mode);
            end else if (tick) begin
                psc     <= '0;
                counter <= cnt_nxt;
                dir     <= dir_nxt;
            end else begin
                psc <= psc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_multichan.sv
// Multi-channel PWM generator with double-buffered duty registers.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                1 = run, 0 = timebase held at 0 and outputs low
//   center_mode       0 = edge-aligned, 1 = centre-aligned (taken at boundary)
//   presc             prescaler divide-minus-one (live)
//   period            period value P (taken at boundary)
//   duty_wr           one-cycle strobe writing duty_val into pending[duty_ch]
//   duty_ch           channel index; indices >= N_CH are ignored
//   duty_val          duty value D
//   pwm_out           registered outputs, high while counter < active duty
//   period_tick       one-cycle pulse on every period boundary
module pwm_multichan
    import pwm_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      center_mode,
    input  logic [PRESC_W-1:0]        presc,
    input  logic [WIDTH-1:0]          period,
    input  logic                      duty_wr,
    input  logic [ch_width(N_CH)-1:0] duty_ch,
    input  logic [WIDTH-1:0]          duty_val,
    output logic [N_CH-1:0]           pwm_out,
    output logic                      period_tick
);

    localparam int unsigned CH_W = ch_width(N_CH);

    logic [WIDTH-1:0] counter;
    logic             load;
    logic             run;

    pwm_timebase #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .center_mode (center_mode),
        .presc       (presc),
        .period      (period),
        .counter     (counter),
        .load        (load),
        .run         (run),
        .period_tick (period_tick)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] pending;
        logic [WIDTH-1:0] active;
        logic             out_q;
        logic             hit;

        assign hit        = duty_wr && (duty_ch == CH_W'(i));
        assign pwm_out[i] = out_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                pending <= '0;
                active  <= '0;
                out_q   <= 1'b0;
            end else begin
                if (hit) pending <= duty_val;
                // A write landing on the boundary goes straight into active
                if (load) active <= hit ? duty_val : pending;
                // Held low on the forced first boundary while new settings load
                out_q <= run && (counter < active);
            end
        end
    end

endmodule

// File: tb/tb_pwm_multichan.sv
module tb_pwm_multichan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       center_mode;
    logic [3:0] presc;
    logic [7:0] period;
    logic       duty_wr;
    logic [1:0] duty_ch;
    logic [7:0] duty_val;
    logic [3:0] pwm_out;
    logic       period_tick;

    pwm_multichan #(
        .N_CH    (4),
        .WIDTH   (8),
        .PRESC_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .center_mode (center_mode),
        .presc       (presc),
        .period      (period),
        .duty_wr     (duty_wr),
        .duty_ch     (duty_ch),
        .duty_val    (duty_val),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int hi[4];
    } win_t;

    win_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: a window runs from the cycle after one period_tick up to and
    // including the next period_tick cycle, matching the one-clock output lag.
    bit in_win = 0;
    int m_len;
    int m_hi[4];
    int win_no = 0;

    always @(negedge clk) begin
        if (rst || !en) begin
            in_win = 0;
        end else begin
            if (in_win) begin
                m_len++;
                for (int c = 0; c < 4; c++) if (pwm_out[c]) m_hi[c]++;
            end
            if (period_tick) begin
                if (in_win && exp_q.size() > 0) begin
                    win_t w;
                    w = exp_q.pop_front();
                    win_no++;
                    check($sformatf("win%0d_len", win_no), m_len, w.len);
                    for (int c = 0; c < 4; c++)
                        check($sformatf("win%0d_high_ch%0d", win_no, c), m_hi[c], w.hi[c]);
                end
                in_win = 1;
                m_len  = 0;
                for (int c = 0; c < 4; c++) m_hi[c] = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int len, input int h0, input int h1, input int h2, input int h3);
        win_t w;
        w.len = len;
        w.hi[0] = h0; w.hi[1] = h1; w.hi[2] = h2; w.hi[3] = h3;
        exp_q.push_back(w);
    endtask

    task automatic wr(input int ch, input int val);
        duty_wr  = 1'b1;
        duty_ch  = 2'(ch);
        duty_val = 8'(val);
        step();
        duty_wr  = 1'b0;
    endtask

    // Returns in the period_tick cycle of the last expected window
    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        check({name, "_pending_windows"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; center_mode = 1'b0; presc = '0; period = '0;
        duty_wr = 1'b0; duty_ch = '0; duty_val = '0;
        repeat (3) step();
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_period_tick", int'(period_tick), 0);
        rst = 1'b0;

        // T1/T2: edge P=9, duties 3,0,10(>P),5 written while disabled
        period = 8'd9;
        wr(0, 3); wr(1, 0); wr(2, 10); wr(3, 5);
        check("disabled_pwm_out", int'(pwm_out), 0);
        repeat (3) push(10, 3, 0, 10, 5);
        en = 1'b1;
        drain("t1");

        // T3: mid-period write applies next period
        wr(0, 7);
        push(10, 3, 0, 10, 5);
        push(10, 7, 0, 10, 5);
        drain("t3a");

        // T3: write coincident with boundary bypasses into active
        push(10, 7, 0, 10, 5);
        push(10, 2, 0, 10, 5);
        repeat (9) step();
        wr(0, 2);
        drain("t3b");

        // T4: centre P=4, duties 2,0,5,4
        center_mode = 1'b1; period = 8'd4;
        wr(1, 0); wr(2, 5); wr(3, 4);
        push(10, 2, 0, 10, 5);
        push(8, 3, 0, 8, 7);
        push(8, 3, 0, 8, 7);
        drain("t4");

        // T5: edge P=9, presc=2, duties 5,9,1,0
        center_mode = 1'b0; period = 8'd9;
        wr(0, 5); wr(1, 9); wr(2, 1); wr(3, 0);
        push(8, 3, 0, 8, 7);
        drain("t5a");
        presc = 4'd2;
        push(30, 15, 27, 3, 0);
        push(30, 15, 27, 3, 0);
        drain("t5b");

        // T6: en dropped mid-period
        repeat (7) step();
        en = 1'b0;
        step();
        check("en0_pwm_out", int'(pwm_out), 0);
        check("en0_period_tick", int'(period_tick), 0);
        presc = 4'd0;
        repeat (3) step();
        check("en0_hold_pwm_out", int'(pwm_out), 0);
        push(10, 5, 9, 1, 0);
        push(10, 5, 9, 1, 0);
        en = 1'b1;
        step();
        check("reen_period_tick", int'(period_tick), 1);
        check("reen_pwm_out", int'(pwm_out), 0);
        drain("t6a");

        // T6: reset mid-period with en held high
        repeat (4) step();
        rst = 1'b1;
        step();
        check("rst_mid_pwm_out", int'(pwm_out), 0);
        check("rst_mid_period_tick", int'(period_tick), 0);
        step();
        rst = 1'b0;
        push(10, 0, 0, 0, 0);
        step();
        check("post_rst_period_tick", int'(period_tick), 1);
        drain("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
